// File: rtl/msg_frame_buffer.sv
// msg_frame_buffer: store-and-forward message buffer. Words are written
// speculatively and committed on IN_LAST; committed lengths go to a length
// queue; a read FSM (IDLE/READ/GAP) streams whole messages out and enforces
// an idle gap after each one.
// Optional feature: define MSG_DROP_CNT_EN to add the saturating DROP_CNT port.
module msg_frame_buffer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned LQ_ADDR_W  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  input  logic              IN_LAST,
  input  logic              RD_REQ,
  output logic [DATA_W-1:0] OUT_Q,
  output logic              GOT_FULL_MSG,
  output logic [LEN_W-1:0]  MSG_LEN_OUT,
  output logic [LQ_ADDR_W:0] MSG_CNT
`ifdef MSG_DROP_CNT_EN
  ,
  output logic [15:0]       DROP_CNT
`endif
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned LQ_DEPTH = 1 << LQ_ADDR_W;
  localparam int unsigned PTR_W    = ADDR_W + 1;
  localparam int unsigned CNT_W    = LQ_ADDR_W + 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

  logic [DATA_W-1:0]    mem    [DEPTH];
  logic [LEN_W-1:0]     lq_mem [LQ_DEPTH];

  logic [PTR_W-1:0]     wr_spec_q, wr_cmt_q, rd_ptr_q;
  logic [LQ_ADDR_W-1:0] lq_wr_q, lq_rd_q, lq_head;
  logic [CNT_W-1:0]     msg_cnt_q, msg_cnt_d;
  logic [LEN_W-1:0]     wr_cnt_q, rd_cnt_q, cur_cnt, new_len;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [DATA_W-1:0]    out_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [PTR_W-1:0]     used;
  logic                 msg_open_q, dropping_q;
  logic                 store_full, lq_full, wr_fail, wr_ok, push, pop, rd_acc;
  logic                 got_q, got_d;
  state_t               state_q, state_d;

  assign OUT_Q        = out_q;
  assign GOT_FULL_MSG = got_q;
  assign MSG_LEN_OUT  = len_q;
  assign MSG_CNT      = msg_cnt_q;

  // Write-side admission: decide whether the current word is stored, fails or is skipped
  always_comb begin
    used       = wr_spec_q - rd_ptr_q;
    store_full = (used == PTR_W'(DEPTH));
    lq_full    = (msg_cnt_q == CNT_W'(LQ_DEPTH));
    cur_cnt    = msg_open_q ? wr_cnt_q : '0;
    new_len    = cur_cnt + LEN_W'(1);
    wr_fail    = 1'b0;
    wr_ok      = 1'b0;
    push       = 1'b0;
    if (IN_VALID && !dropping_q) begin
      wr_fail = store_full || (cur_cnt == MAX_LEN) || (IN_LAST && lq_full);
      wr_ok   = !wr_fail;
      push    = wr_ok && IN_LAST;
    end
  end

  // Write pointers and message framing state
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      wr_spec_q  <= '0;
      wr_cmt_q   <= '0;
      wr_cnt_q   <= '0;
      msg_open_q <= 1'b0;
      dropping_q <= 1'b0;
    end else if (IN_VALID) begin
      if (dropping_q) begin
        if (IN_LAST) dropping_q <= 1'b0;
      end else if (wr_fail) begin
        wr_spec_q  <= wr_cmt_q;
        msg_open_q <= 1'b0;
        dropping_q <= !IN_LAST;
      end else begin
        wr_spec_q <= wr_spec_q + PTR_W'(1);
        wr_cnt_q  <= new_len;
        if (IN_LAST) begin
          wr_cmt_q   <= wr_spec_q + PTR_W'(1);
          msg_open_q <= 1'b0;
        end else begin
          msg_open_q <= 1'b1;
        end
      end
    end
  end

  // Data store write port (contents need no reset; pointers define validity)
  always_ff @(posedge SYS_CLK) begin
    if (wr_ok) mem[wr_spec_q[ADDR_W-1:0]] <= IN_DATA;
  end

  // Length queue storage
  always_ff @(posedge SYS_CLK) begin
    if (push) lq_mem[lq_wr_q] <= new_len;
  end

  // Read FSM next-state and read/pop strobes
  always_comb begin
    state_d = state_q;
    rd_acc  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RD_REQ && got_q) begin
          rd_acc = 1'b1;
          if (len_q == LEN_W'(1)) begin
            pop     = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (RD_REQ) begin
          rd_acc = 1'b1;
          if ((rd_cnt_q + LEN_W'(1)) == len_q) begin
            pop     = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next message count, availability flag and head length (bypass when pushing into an empty queue)
  always_comb begin
    msg_cnt_d = msg_cnt_q + CNT_W'(push) - CNT_W'(pop);
    got_d     = (state_d == S_READ) || ((state_d == S_IDLE) && (msg_cnt_d != '0));
    lq_head   = lq_rd_q + LQ_ADDR_W'(pop);
    if (msg_cnt_d == '0) begin
      len_d = '0;
    end else if (push && (msg_cnt_q == CNT_W'(pop))) begin
      len_d = new_len;
    end else begin
      len_d = lq_mem[lq_head];
    end
  end

  // Length queue pointers, message count and head length register
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      lq_wr_q   <= '0;
      lq_rd_q   <= '0;
      msg_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      if (push) lq_wr_q <= lq_wr_q + LQ_ADDR_W'(1);
      if (pop)  lq_rd_q <= lq_rd_q + LQ_ADDR_W'(1);
      msg_cnt_q <= msg_cnt_d;
      len_q     <= len_d;
    end
  end

  // FSM state register
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Read datapath: pointer, word count within message, gap timer, output data
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr_q  <= '0;
      rd_cnt_q  <= '0;
      gap_cnt_q <= '0;
      out_q     <= '0;
      got_q     <= 1'b0;
    end else begin
      got_q     <= got_d;
      gap_cnt_q <= (state_q == S_GAP) ? gap_cnt_q + GAP_W'(1) : '0;
      if (rd_acc) begin
        out_q    <= mem[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        rd_cnt_q <= (state_q == S_IDLE) ? LEN_W'(1) : rd_cnt_q + LEN_W'(1);
      end
    end
  end

`ifdef MSG_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped messages, bumped on the first failing word
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_q <= '0;
    end else if (wr_fail && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule
